store_packer: RTL and testbench

- Store-path counterpart of the load extender. It narrows a 32-bit register value to byte, halfword or word store data.
- It replicates the data across the correct lanes and generates byte enables.
- It drives one write transaction to data memory over a valid/ready handshake.
- It sits between the MIPS execute/memory stage and the data-memory port, with a watchdog on the memory handshake.

---
 rtl/store_packer_if.sv | 28 ++
 rtl/store_packer.sv | 132 +++++++++++++
 tb/tb_store_packer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_packer_if.sv
// Store packer bus interface: request side from the execute/memory stage,
// write side toward the data-memory port, plus status pulses.
// master = requester / memory model, slave = store_packer.
interface store_packer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err, busy
    );
endinterface

// File: rtl/store_packer.sv
// Store packer: narrows a 32-bit register value to byte/half/word store data,
// replicates it across byte lanes, builds byte enables and issues a single
// write to data memory over valid/ready, guarded by a watchdog.
// Optional build macro STORE_MISALIGN_TRAP_EN: reject misaligned half/word
// stores with an err pulse instead of silently forcing alignment.
module store_packer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    store_packer_if.slave bus
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state;
    logic             req_ready_r;
    logic             mem_valid_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic [3:0]       mem_be_r;
    logic             done_r;
    logic             err_r;
    logic             busy_r;
    logic [CNT_W-1:0] wdog;
    logic [CNT_W-1:0] wdog_next;

    logic [31:0]      pack_wdata;
    logic [3:0]       pack_be;
    logic             reject;

    assign wdog_next = wdog + CNT_W'(1);

    // Lane replication, byte-enable generation and request legality check
    always_comb begin
        pack_wdata = bus.req_data;
        pack_be    = 4'b0000;
        reject     = 1'b0;
        case (bus.req_size)
            2'b00: begin
                pack_wdata = {4{bus.req_data[7:0]}};
                pack_be    = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                pack_wdata = {2{bus.req_data[15:0]}};
                pack_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
                reject     = bus.req_addr[0];
`endif
            end
            2'b10: begin
                pack_wdata = bus.req_data;
                pack_be    = 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
                reject     = (bus.req_addr[1:0] != 2'b00);
`endif
            end
            default: begin
                reject     = 1'b1;
            end
        endcase
    end

    // Request/issue FSM with registered outputs and handshake watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_r <= 1'b1;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            wdog        <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (reject) begin
                            err_r <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            req_ready_r <= 1'b0;
                            busy_r      <= 1'b1;
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_r <= pack_wdata;
                            mem_be_r    <= pack_be;
                            wdog        <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        state       <= IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        mem_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                    end else if (wdog_next == CNT_W'(TIMEOUT)) begin
                        state       <= IDLE;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        mem_valid_r <= 1'b0;
                        err_r       <= 1'b1;
                        wdog        <= wdog_next;
                    end else begin
                        wdog        <= wdog_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_store_packer.sv
// Testbench for store_packer: directed store requests with hand-computed
// expected writes pushed into a scoreboard; an independent monitor pops and
// compares on each memory handshake or err pulse.
module tb_store_packer;

    localparam int TIMEOUT = 15;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic clk;
    logic rst;
    int   applied;
    int   miscompares;
    exp_t sb[$];

    store_packer_if bus();

    store_packer #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls forever
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: scoreboard pops on handshakes and err pulses, stall stability
    initial begin : monitor
        bit          expect_done;
        bit          stalled;
        logic [31:0] held_addr;
        logic [31:0] held_wdata;
        logic [3:0]  held_be;
        exp_t        e;
        expect_done = 1'b0;
        stalled     = 1'b0;
        held_addr   = '0;
        held_wdata  = '0;
        held_be     = '0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.err === 1'b1)
                checkOutput("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
            if (expect_done) begin
                checkOutput("done_pulse", 32'(bus.done), 32'd1);
                expect_done = 1'b0;
            end else if (bus.done === 1'b1) begin
                checkOutput("unexpected_done", 32'(bus.done), 32'd0);
            end
            if (bus.err === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_err", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("err_expected", 32'd1, 32'(e.is_err));
                end
            end
            if (bus.mem_valid === 1'b1) begin
                if (stalled) begin
                    checkOutput("hold_addr", bus.mem_addr, held_addr);
                    checkOutput("hold_wdata", bus.mem_wdata, held_wdata);
                    checkOutput("hold_be", 32'(bus.mem_be), 32'(held_be));
                    checkOutput("ready_low_busy", 32'({bus.req_ready, bus.busy}), 32'b01);
                end
                if (bus.mem_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("write_expected", 32'(e.is_err), 32'd0);
                        checkOutput("mem_addr", bus.mem_addr, e.addr);
                        checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
                        checkOutput("mem_be", 32'(bus.mem_be), 32'(e.be));
                    end
                    expect_done = 1'b1;
                    stalled     = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    held_addr  = bus.mem_addr;
                    held_wdata = bus.mem_wdata;
                    held_be    = bus.mem_be;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Push expectation, wait for req_ready, present request for one accepting edge
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input bit exp_err,
                                 input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                 input logic [3:0] e_be);
        exp_t e;
        int   n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.req_ready !== 1'b1)
            checkOutput("req_ready_wait", 32'(bus.req_ready), 32'd1);
        e.is_err = exp_err;
        e.addr   = e_addr;
        e.wdata  = e_wdata;
        e.be     = e_be;
        sb.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Count negedges after the accepting edge until done or err (bounded)
    task automatic waitResponse(input int base, output int lat);
        int k;
        bit got;
        k   = base;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (bus.done === 1'b1 || bus.err === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checkOutput("response_wait", 32'd0, 32'd1);
            lat = -1;
        end else begin
            lat = k;
        end
    endtask

    // Directed stimulus sequence
    initial begin : stimulus
        int lat;
        applied       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
        bus.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", 32'({bus.mem_valid, bus.done, bus.err, bus.busy, bus.mem_be}), 32'd0);
        checkOutput("reset_addr", bus.mem_addr, 32'd0);
        checkOutput("reset_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Byte store to lane 3
        applyStimulus(32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000);
        waitResponse(0, lat);
        checkOutput("lat_byte", 32'(lat), 32'd2);
        @(posedge clk);
        #1;

        // Byte store to lane 1
        applyStimulus(32'h0000_0005, 32'h0000_00AB, 2'b00, 1'b0, 32'h0000_0004, 32'hABAB_ABAB, 4'b0010);
        waitResponse(0, lat);
        @(posedge clk);
        #1;

        // Half store, upper half
        applyStimulus(32'h0000_2002, 32'h1234_5678, 2'b01, 1'b0, 32'h0000_2000, 32'h5678_5678, 4'b1100);
        waitResponse(0, lat);
        checkOutput("lat_half", 32'(lat), 32'd2);
        @(posedge clk);
        #1;

        // Half store, lower half, upper data bits discarded
        applyStimulus(32'h0000_3000, 32'hFFFF_BEEF, 2'b01, 1'b0, 32'h0000_3000, 32'hBEEF_BEEF, 4'b0011);
        waitResponse(0, lat);
        @(posedge clk);
        #1;

        // Word store with 5-cycle memory stall
        bus.mem_ready = 1'b0;
        applyStimulus(32'h0000_0040, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
        repeat (5) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        waitResponse(5, lat);
        checkOutput("lat_stall", 32'(lat), 32'd7);
        @(posedge clk);
        #1;

        // Watchdog timeout
        bus.mem_ready = 1'b0;
        applyStimulus(32'h0000_0080, 32'h0BAD_C0DE, 2'b10, 1'b1, 32'h0, 32'h0, 4'h0);
        waitResponse(0, lat);
        checkOutput("lat_timeout", 32'(lat), 32'(TIMEOUT + 1));
        checkOutput("timeout_valid_ready", 32'({bus.mem_valid, bus.req_ready}), 32'b01);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;

        // Reserved size: err next cycle, no write
        applyStimulus(32'h0000_0010, 32'h5555_AAAA, 2'b11, 1'b1, 32'h0, 32'h0, 4'h0);
        waitResponse(0, lat);
        checkOutput("lat_reserved", 32'(lat), 32'd1);
        checkOutput("reserved_no_valid", 32'(bus.mem_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a stalled transaction
        bus.mem_ready = 1'b0;
        applyStimulus(32'h0000_0100, 32'h0102_0304, 2'b10, 1'b0, 32'h0000_0100, 32'h0102_0304, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ctrl", 32'({bus.mem_valid, bus.done, bus.err, bus.busy, bus.mem_be}), 32'd0);
        checkOutput("midreset_addr", bus.mem_addr, 32'd0);
        checkOutput("midreset_wdata", bus.mem_wdata, 32'd0);
        checkOutput("midreset_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;

        // Misaligned word store
`ifdef STORE_MISALIGN_TRAP_EN
        applyStimulus(32'h0000_0041, 32'h1122_3344, 2'b10, 1'b1, 32'h0, 32'h0, 4'h0);
        waitResponse(0, lat);
        checkOutput("lat_misalign", 32'(lat), 32'd1);
`else
        applyStimulus(32'h0000_0041, 32'h1122_3344, 2'b10, 1'b0, 32'h0000_0040, 32'h1122_3344, 4'b1111);
        waitResponse(0, lat);
        checkOutput("lat_misalign", 32'(lat), 32'd2);
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
